// File: rtl/chan_dump_if.sv
// Dump engine bus: command inputs, shared capture-RAM read port,
// and the UART byte handshake.
interface chan_dump_if #(
    parameter int LOG2 = 9
);
    logic            dump_start;
    logic [2:0]      dump_chan;
    logic [LOG2-1:0] start_addr;
    logic [LOG2-1:0] ram_addr;
    logic            ram_rd;
    logic [7:0]      ch1_rdata;
    logic [7:0]      ch2_rdata;
    logic [7:0]      ch3_rdata;
    logic [7:0]      ch4_rdata;
    logic [7:0]      ch5_rdata;
    logic [7:0]      tx_data;
    logic            send_resp;
    logic            resp_sent;
    logic            busy;
    logic            dump_done;

    modport master (
        input  dump_start,
        input  dump_chan,
        input  start_addr,
        output ram_addr,
        output ram_rd,
        input  ch1_rdata,
        input  ch2_rdata,
        input  ch3_rdata,
        input  ch4_rdata,
        input  ch5_rdata,
        output tx_data,
        output send_resp,
        input  resp_sent,
        output busy,
        output dump_done
    );

    modport slave (
        output dump_start,
        output dump_chan,
        output start_addr,
        input  ram_addr,
        input  ram_rd,
        output ch1_rdata,
        output ch2_rdata,
        output ch3_rdata,
        output ch4_rdata,
        output ch5_rdata,
        input  tx_data,
        input  send_resp,
        output resp_sent,
        input  busy,
        input  dump_done
    );
endinterface

// File: rtl/chan_dump_ctrl.sv
// Channel dump engine: streams one capture RAM, oldest sample
// first, to the UART transmitter one byte per handshake.
module chan_dump_ctrl #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic          clk,
    input  logic          rst,
    chan_dump_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LD,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
    localparam logic [LOG2:0]   ENT  = (LOG2 + 1)'(ENTRIES);

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_chan;
    logic [LOG2-1:0] r_addr;
    logic [LOG2-1:0] r_cnt;
    logic [7:0]      r_tx;
    logic            r_busy;
    logic [7:0]      w_rdata;
    logic            w_chan_ok;
    logic            w_addr_ok;

    assign w_chan_ok = (bus.dump_chan <= 3'd4);
    assign w_addr_ok = ({1'b0, bus.start_addr} < ENT);

    always_comb begin
        w_rdata = 8'h00;
        unique case (r_chan)
            3'd0:    w_rdata = bus.ch1_rdata;
            3'd1:    w_rdata = bus.ch2_rdata;
            3'd2:    w_rdata = bus.ch3_rdata;
            3'd3:    w_rdata = bus.ch4_rdata;
            3'd4:    w_rdata = bus.ch5_rdata;
            default: w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // resp_sent is only honoured in WAIT, so a pulse coincident
    // with send_resp (state SEND) is dropped.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.dump_start) begin
                    w_next = w_chan_ok ? S_RD : S_SEND;
                end
            end
            S_RD:   w_next = S_LD;
            S_LD:   w_next = S_SEND;
            S_SEND: w_next = S_WAIT;
            S_WAIT: begin
                if (bus.resp_sent) begin
                    w_next = (r_cnt == LAST) ? S_DONE : S_RD;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chan <= 3'd0;
            r_addr <= '0;
            r_cnt  <= '0;
            r_tx   <= 8'h00;
            r_busy <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.dump_start) begin
                        r_busy <= 1'b1;
                        if (w_chan_ok) begin
                            r_chan <= bus.dump_chan;
                            r_addr <= w_addr_ok ?
                                      bus.start_addr : '0;
                            r_cnt  <= '0;
                        end else begin
                            // bad channel: one error byte, then done
                            r_tx  <= 8'hEE;
                            r_cnt <= LAST;
                        end
                    end
                end
                S_LD: r_tx <= w_rdata;
                S_WAIT: begin
                    if (bus.resp_sent && (r_cnt != LAST)) begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_addr <= (r_addr == LAST) ?
                                  '0 : r_addr + 1'b1;
                    end
                end
                S_DONE:  r_busy <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.ram_addr  = r_addr;
    assign bus.ram_rd    = (r_state == S_RD);
    assign bus.tx_data   = r_tx;
    assign bus.send_resp = (r_state == S_SEND);
    assign bus.busy      = r_busy;
    assign bus.dump_done = (r_state == S_DONE);
endmodule

// File: tb/tb_chan_dump_ctrl.sv
// Directed bench for chan_dump_ctrl: vector table of whole dumps
// plus hand sequences for latency, restart, reset and stray pulses.
module tb_chan_dump_ctrl;
    localparam int N = 384;

    typedef struct {
        int chan;
        int sa;
        int dly;
        int salt;
        int inj;
        int n_exp;
        int first;
        int last;
    } vec_t;

    logic clk;
    logic rst;
    logic r_auto;
    logic r_stray;
    int   resp_delay;
    int   salt;
    int   n_cmp;
    int   n_fail;
    int   done_cnt;
    int   rd_cnt;
    int   stab_err;
    int   addr_err;
    logic [7:0] q[$];
    logic [7:0] hold;
    bit   holding;
    logic [7:0] rd [5];
    vec_t vecs [8];

    chan_dump_if #(.LOG2(9)) bus ();

    chan_dump_ctrl #(
        .ENTRIES(N),
        .LOG2(9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.resp_sent = r_auto | r_stray;
    assign bus.ch1_rdata = rd[0];
    assign bus.ch2_rdata = rd[1];
    assign bus.ch3_rdata = rd[2];
    assign bus.ch4_rdata = rd[3];
    assign bus.ch5_rdata = rd[4];

    function automatic logic [7:0] tag(input int k);
        return (salt != 0) ? 8'((k + 1) * 16) : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (bus.ram_rd) begin
            for (int k = 0; k < 5; k++) begin
                rd[k] <= bus.ram_addr[7:0] ^ tag(k);
            end
        end
    end

    always begin
        @(negedge clk);
        if (bus.send_resp && !rst) begin
            repeat (resp_delay + 1) @(negedge clk);
            r_auto = 1'b1;
            @(negedge clk);
            r_auto = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            holding = 1'b0;
        end else if (bus.send_resp) begin
            q.push_back(bus.tx_data);
            hold    = bus.tx_data;
            holding = 1'b1;
        end else if (holding && bus.tx_data != hold) begin
            stab_err++;
        end
        if (bus.dump_done) begin
            done_cnt++;
            holding = 1'b0;
        end
        if (bus.ram_rd) begin
            rd_cnt++;
            if (bus.ram_addr >= 9'(N)) addr_err++;
        end
    end

    task automatic chk(input string nm, input int act,
                       input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     nm, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int ch,
                                            input int sa,
                                            input int i);
        int a;
        if (ch > 4) return 8'hEE;
        a = (((sa >= N) ? 0 : sa) + i) % N;
        return 8'(a % 256) ^ tag(ch);
    endfunction

    task automatic start(input int ch, input int sa);
        bus.dump_chan  = 3'(ch);
        bus.start_addr = 9'(sa);
        bus.dump_start = 1'b1;
        @(negedge clk);
        bus.dump_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int b,
                             input int limit, input int inj);
        int n;
        bit fired;
        n = 0;
        fired = 1'b0;
        while (done_cnt == d0 && n < limit) begin
            if (inj >= 0 && !fired && q.size() - b >= inj) begin
                bus.dump_chan  = 3'd1;
                bus.start_addr = 9'd200;
                bus.dump_start = 1'b1;
                fired = 1'b1;
            end
            @(negedge clk);
            bus.dump_start = 1'b0;
            n++;
        end
        chk("done_pulses", done_cnt - d0, 1);
    endtask

    task automatic do_vec(input vec_t v);
        int b, d0, r0, s0, a0, got;
        b  = q.size();
        d0 = done_cnt;
        r0 = rd_cnt;
        s0 = stab_err;
        a0 = addr_err;
        resp_delay = v.dly;
        salt = v.salt;
        start(v.chan, v.sa);
        wait_done(d0, b, N * (v.dly + 8) + 50, v.inj);
        @(negedge clk);
        got = q.size() - b;
        chk("byte_count", got, v.n_exp);
        if (got > 0) begin
            chk("first_byte", int'(q[b]), v.first);
            chk("last_byte", int'(q[q.size() - 1]), v.last);
        end
        for (int i = 0; i < got && i < v.n_exp; i++) begin
            chk($sformatf("byte[%0d]", i), int'(q[b + i]),
                int'(exp_byte(v.chan, v.sa, i)));
        end
        chk("ram_reads", rd_cnt - r0,
            (v.chan > 4) ? 0 : v.n_exp);
        chk("busy_after", int'(bus.busy), 0);
        chk("tx_stable", stab_err - s0, 0);
        chk("addr_range", addr_err - a0, 0);
    endtask

    task automatic chk_reset_outs();
        chk("rst_ram_addr", int'(bus.ram_addr), 0);
        chk("rst_ram_rd", int'(bus.ram_rd), 0);
        chk("rst_tx_data", int'(bus.tx_data), 0);
        chk("rst_send_resp", int'(bus.send_resp), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_dump_done", int'(bus.dump_done), 0);
    endtask

    initial begin
        int b, d0, n;
        vec_t rv;
        n_cmp = 0;
        n_fail = 0;
        done_cnt = 0;
        rd_cnt = 0;
        stab_err = 0;
        addr_err = 0;
        holding = 1'b0;
        hold = 8'h00;
        resp_delay = 0;
        salt = 0;
        r_auto = 1'b0;
        r_stray = 1'b0;
        for (int k = 0; k < 5; k++) rd[k] = 8'h00;
        bus.dump_start = 1'b0;
        bus.dump_chan  = 3'd0;
        bus.start_addr = 9'd0;
        rst = 1'b1;

        vecs[0] = '{0, 0,   0,  0, -1, 384, 'h00, 'h7F};
        vecs[1] = '{3, 380, 1,  0, -1, 384, 'h7C, 'h7B};
        vecs[2] = '{5, 0,   0,  0, -1, 1,   'hEE, 'hEE};
        vecs[3] = '{7, 12,  2,  0, -1, 1,   'hEE, 'hEE};
        vecs[4] = '{1, 500, 0,  1, -1, 384, 'h20, 'h5F};
        vecs[5] = '{4, 383, 0,  1, -1, 384, 'h2F, 'h2E};
        vecs[6] = '{0, 0,   0,  1, 10, 384, 'h10, 'h6F};
        vecs[7] = '{0, 100, 50, 0, -1, 384, 'h64, 'h63};

        repeat (3) @(negedge clk);
        chk_reset_outs();
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // start-to-first-byte latency
        b = q.size();
        d0 = done_cnt;
        salt = 0;
        bus.dump_chan  = 3'd2;
        bus.start_addr = 9'd255;
        bus.dump_start = 1'b1;
        @(negedge clk);
        bus.dump_start = 1'b0;
        chk("lat_rd_c1", int'(bus.ram_rd), 1);
        chk("lat_busy_c1", int'(bus.busy), 1);
        chk("lat_send_c1", int'(bus.send_resp), 0);
        @(negedge clk);
        chk("lat_send_c2", int'(bus.send_resp), 0);
        @(negedge clk);
        chk("lat_send_c3", int'(bus.send_resp), 1);
        chk("lat_tx_c3", int'(bus.tx_data), 'hFF);
        wait_done(d0, b, N * 8 + 50, -1);
        @(negedge clk);
        chk("lat_count", q.size() - b, N);

        for (int i = 0; i < 8; i++) do_vec(vecs[i]);

        // reset in the middle of a dump
        resp_delay = 0;
        salt = 0;
        b = q.size();
        d0 = done_cnt;
        start(0, 0);
        n = 0;
        while (q.size() - b < 100 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached", q.size() - b, 100);
        rst = 1'b1;
        #1;
        chk_reset_outs();
        @(negedge clk);
        chk_reset_outs();
        rst = 1'b0;
        b = q.size();
        repeat (20) @(negedge clk);
        chk("abort_no_send", q.size() - b, 0);
        chk("abort_no_done", done_cnt - d0, 0);
        rv = '{2, 10, 0, 0, -1, 384, 'h0A, 'h09};
        do_vec(rv);

        // stray resp_sent while idle
        b = q.size();
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            r_stray = 1'b1;
            @(negedge clk);
            r_stray = 1'b0;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        chk("stray_no_send", q.size() - b, 0);
        chk("stray_no_done", done_cnt - d0, 0);
        chk("stray_busy", int'(bus.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule
